// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the alu_seq instruction sequencer.
// Contents: FSM state encoding, instruction-word field offsets, flow-control codes,
// the HALT opcode, the "no register write" destination code, and a HALT decoder.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_OPERAND = 3'd2,
        ST_COMMIT  = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Instruction word layout (40 bits):
    // [39:32] op, [31:30] s1ch, [29:28] s2ch, [27:26] dch, [25:24] flow,
    // [23:16] src1, [15:8] src2, [7:0] dst
    localparam int OP_LSB   = 32;
    localparam int S1CH_LSB = 30;
    localparam int S2CH_LSB = 28;
    localparam int DCH_LSB  = 26;
    localparam int FLOW_LSB = 24;
    localparam int SRC1_LSB = 16;
    localparam int SRC2_LSB = 8;
    localparam int DST_LSB  = 0;

    localparam logic [1:0] FLOW_NORMAL = 2'b00;
    localparam logic [1:0] FLOW_JZ     = 2'b01;
    localparam logic [1:0] FLOW_CALL   = 2'b10;
    localparam logic [1:0] FLOW_RET    = 2'b11;

    localparam logic [7:0] OP_HALT   = 8'hFF;
    localparam logic [1:0] DEST_NONE = 2'b11;

    // HALT is encoded as a NORMAL-flow instruction carrying the reserved opcode.
    function automatic logic is_halt(input logic [7:0] op, input logic [1:0] flow);
        return (flow == FLOW_NORMAL) && (op == OP_HALT);
    endfunction

endpackage

// File: rtl/alu_seq_ras.sv
// alu_seq_ras: return-address stack (LIFO) for CALL/RET.
// Ports:
//   clk, rst      clock / asynchronous active-low reset (empties the stack)
//   push, pop     one-cycle strobes; push ignored when full, pop ignored when empty
//   clear         synchronous empty, takes priority over push/pop
//   din           address pushed
//   top           current top-of-stack entry (0 when empty)
//   full, empty   occupancy flags
module alu_seq_ras #(
    parameter int DEPTH = 4,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_reg;
    logic [AW-1:0] mem [DEPTH];

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (push && !full) begin
            count_reg <= count_reg + 1'b1;
        end else if (pop && !empty) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Entries need no reset: only slots below count_reg are ever read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && !clear && (count_reg == CW'(i))) begin
                mem[i] <= din;
            end
        end
    end

    // Top-of-stack mux written as a compare chain so the count never has to be
    // used directly as an array index of mismatched width.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_reg == CW'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: instruction sequencer driving alu_mod.
// Fetches a 40-bit instruction at pc over a req/ack handshake, then presents its
// fields for one OPERAND cycle (no write) and one COMMIT cycle (write enabled for
// NORMAL instructions only), then updates pc. Supports JZ, CALL/RET through an
// internal return-address stack mirrored to alu_mod via push/pop, and HALT.
// Ports:
//   clk, rst                          clock / asynchronous active-low reset
//   start                             begin at pc 0 from IDLE or HALT
//   imem_req/imem_addr/imem_ack/imem_data  instruction fetch handshake
//   zero_flag                         alu_mod zero flag, sampled in OPERAND
//   op_code, source1, source2, source1_choice, source2_choice,
//   destination, dest_choice          alu_mod instruction fields (dest_choice 11 = no write)
//   push, pop, instr_addr             stack strobes and return address to alu_mod
//   busy, halted, stack_err           status
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PC_WIDTH    = 6,
    parameter int INSTR_WIDTH = 40,
    parameter int RAS_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   zero_flag,
    output logic [WIDTH-1:0]       op_code,
    output logic [WIDTH-1:0]       source1,
    output logic [WIDTH-1:0]       source2,
    output logic [1:0]             source1_choice,
    output logic [1:0]             source2_choice,
    output logic [WIDTH-1:0]       destination,
    output logic [1:0]             dest_choice,
    output logic                   push,
    output logic                   pop,
    output logic [PC_WIDTH-1:0]    instr_addr,
    output logic                   busy,
    output logic                   halted,
    output logic                   stack_err
);

    state_t                 state_reg;
    logic [PC_WIDTH-1:0]    pc_reg;
    logic [INSTR_WIDTH-1:0] ir_reg;
    logic                   zf_q_reg;
    logic                   stack_err_reg;

    logic [1:0]          ir_flow;
    logic [1:0]          ir_dch;
    logic                halt_instr;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;
    logic                in_commit;
    logic                can_start;
    logic                do_push;
    logic                do_pop;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_full;
    logic                ras_empty;

    // Fields come straight from the IR, which only reloads on a fetch ack, so
    // they hold their last values outside OPERAND/COMMIT automatically.
    assign op_code        = ir_reg[OP_LSB   +: WIDTH];
    assign source1        = ir_reg[SRC1_LSB +: WIDTH];
    assign source2        = ir_reg[SRC2_LSB +: WIDTH];
    assign destination    = ir_reg[DST_LSB  +: WIDTH];
    assign source1_choice = ir_reg[S1CH_LSB +: 2];
    assign source2_choice = ir_reg[S2CH_LSB +: 2];
    assign ir_dch         = ir_reg[DCH_LSB  +: 2];
    assign ir_flow        = ir_reg[FLOW_LSB +: 2];

    assign halt_instr = is_halt(op_code, ir_flow);
    assign pc_inc     = pc_reg + 1'b1;  // wraps silently at the top of the address space
    assign target     = destination[PC_WIDTH-1:0];
    assign in_commit  = (state_reg == ST_COMMIT);
    assign can_start  = start && ((state_reg == ST_IDLE) || (state_reg == ST_HALT));

    // Stack strobes are suppressed on overflow/underflow; those cases halt instead.
    assign do_push = in_commit && (ir_flow == FLOW_CALL) && !ras_full;
    assign do_pop  = in_commit && (ir_flow == FLOW_RET)  && !ras_empty;

    // All handshake/strobe outputs decode the asynchronously reset state, so
    // they fall the moment reset is asserted.
    assign imem_req    = (state_reg == ST_FETCH);
    assign imem_addr   = pc_reg;
    assign push        = do_push;
    assign pop         = do_pop;
    assign instr_addr  = do_push ? pc_inc : '0;
    assign dest_choice = (in_commit && (ir_flow == FLOW_NORMAL) && !halt_instr) ? ir_dch : DEST_NONE;
    assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_OPERAND) || in_commit;
    assign halted      = (state_reg == ST_HALT);
    assign stack_err   = stack_err_reg;

    alu_seq_ras #(
        .DEPTH (RAS_DEPTH),
        .AW    (PC_WIDTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .clear (can_start),
        .din   (pc_inc),
        .top   (ras_top),
        .full  (ras_full),
        .empty (ras_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= '0;
            ir_reg        <= '0;
            zf_q_reg      <= 1'b0;
            stack_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state_reg     <= ST_FETCH;
                        pc_reg        <= '0;
                        stack_err_reg <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir_reg    <= imem_data;
                        state_reg <= ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    zf_q_reg  <= zero_flag;
                    state_reg <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state_reg <= ST_FETCH;
                    case (ir_flow)
                        FLOW_NORMAL: begin
                            if (halt_instr) begin
                                state_reg <= ST_HALT;
                            end else begin
                                pc_reg <= pc_inc;
                            end
                        end
                        FLOW_JZ: begin
                            pc_reg <= zf_q_reg ? target : pc_inc;
                        end
                        FLOW_CALL: begin
                            if (ras_full) begin
                                stack_err_reg <= 1'b1;
                                state_reg     <= ST_HALT;
                            end else begin
                                pc_reg <= target;
                            end
                        end
                        default: begin  // FLOW_RET
                            if (ras_empty) begin
                                stack_err_reg <= 1'b1;
                                state_reg     <= ST_HALT;
                            end else begin
                                pc_reg <= ras_top;
                            end
                        end
                    endcase
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
